// File: rtl/ga_fit_sched.sv
// Generation scheduler for a shared fitness datapath: issues P x B sample requests,
// collects one accumulated fitness per individual and tracks the lowest (best) one.
module ga_fit_sched #(
    parameter  int P_MAX   = 1024,
    parameter  int B_MAX   = 64,
    parameter  int FIT_W   = 24,
    localparam int P_MAX_W = $clog2(P_MAX + 1),
    localparam int B_MAX_W = $clog2(B_MAX + 1),
    localparam int P_IDX_W = $clog2(P_MAX),
    localparam int B_IDX_W = $clog2(B_MAX)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [P_MAX_W-1:0] cnfg_p,
    input  logic [B_MAX_W-1:0] cnfg_b,
    input  logic               start_pls,
    input  logic               stop_pls,
    output logic               busy,
    output logic               fit_req_vld,
    input  logic               fit_req_rdy,
    output logic [P_IDX_W-1:0] fit_req_p_idx,
    output logic [B_IDX_W-1:0] fit_req_b_idx,
    output logic               fit_req_last,
    input  logic               fit_rsp_vld,
    input  logic [FIT_W-1:0]   fit_rsp_val,
    output logic               done_pls,
    output logic [P_IDX_W-1:0] best_idx,
    output logic [FIT_W-1:0]   best_fit
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DONE} state_t;

    state_t             state_q;
    logic [P_MAX_W-1:0] p_cfg_q, p_cfg_d;
    logic [B_MAX_W-1:0] b_cfg_q, b_cfg_d;
    logic [P_IDX_W-1:0] p_q;
    logic [B_IDX_W-1:0] b_q;
    logic [P_IDX_W-1:0] best_idx_q;
    logic [FIT_W-1:0]   best_fit_q;
    logic               done_q;
    logic               b_is_last;
    logic               p_is_last;

    // Oversized requests are clamped so the index counters can never wrap.
    always_comb begin
        p_cfg_d = (cnfg_p > P_MAX_W'(P_MAX)) ? P_MAX_W'(P_MAX) : cnfg_p;
        b_cfg_d = (cnfg_b > B_MAX_W'(B_MAX)) ? B_MAX_W'(B_MAX) : cnfg_b;
    end

    assign b_is_last = (B_MAX_W'(b_q) + B_MAX_W'(1)) == b_cfg_q;
    assign p_is_last = (P_MAX_W'(p_q) + P_MAX_W'(1)) == p_cfg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            p_cfg_q    <= '0;
            b_cfg_q    <= '0;
            p_q        <= '0;
            b_q        <= '0;
            best_idx_q <= '0;
            best_fit_q <= '1;
            done_q     <= 1'b0;
        end else begin
            // NOTE: done_q defaults low every cycle, so it can only ever be a one-cycle pulse.
            done_q <= 1'b0;
            if (stop_pls && state_q != IDLE) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_pls && !stop_pls) begin
                            p_cfg_q    <= p_cfg_d;
                            b_cfg_q    <= b_cfg_d;
                            p_q        <= '0;
                            b_q        <= '0;
                            best_idx_q <= '0;
                            best_fit_q <= '1;
                            state_q    <= (p_cfg_d == '0 || b_cfg_d == '0) ? DONE : ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (fit_req_rdy) begin
                            if (b_is_last) state_q <= WAIT_RSP;
                            else           b_q     <= b_q + B_IDX_W'(1);
                        end
                    end
                    WAIT_RSP: begin
                        if (fit_rsp_vld) begin
                            // Strict compare: on a tie the earlier individual stays best.
                            if (fit_rsp_val < best_fit_q) begin
                                best_fit_q <= fit_rsp_val;
                                best_idx_q <= p_q;
                            end
                            if (p_is_last) begin
                                state_q <= DONE;
                            end else begin
                                p_q     <= p_q + P_IDX_W'(1);
                                b_q     <= '0;
                                state_q <= ISSUE;
                            end
                        end
                    end
                    DONE: begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy          = (state_q != IDLE);
    assign fit_req_vld   = (state_q == ISSUE);
    assign fit_req_p_idx = p_q;
    assign fit_req_b_idx = b_q;
    assign fit_req_last  = fit_req_vld && b_is_last;
    assign done_pls      = done_q;
    assign best_idx      = best_idx_q;
    assign best_fit      = best_fit_q;

endmodule

// File: tb/tb_ga_fit_sched.sv
// Self-checking bench for ga_fit_sched: table vectors, randomized generations against
// a nested-loop reference model, and hand-written stop/reset/zero-size sequences.
module tb_ga_fit_sched;

    localparam int P_MAX   = 8;
    localparam int B_MAX   = 4;
    localparam int FIT_W   = 12;
    localparam int P_MAX_W = $clog2(P_MAX + 1);
    localparam int B_MAX_W = $clog2(B_MAX + 1);
    localparam int P_IDX_W = $clog2(P_MAX);
    localparam int B_IDX_W = $clog2(B_MAX);
    localparam int ONES    = (1 << FIT_W) - 1;

    typedef logic [7:0][FIT_W-1:0] vals_t;

    typedef struct {
        int    cp;
        int    cb;
        int    mode;     // 0: rdy always, 1: rdy toggles, 2: random rdy/latency/noise
        vals_t vals;
        int    exp_idx;
        int    exp_fit;
        int    exp_n;
    } vec_t;

    typedef struct {
        int n_xfer;
        int n_done;
        int done_cycle;
        bit seq_ok;
        bit stable_ok;
        bit wait_ok;
        bit first_vld;
    } res_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [P_MAX_W-1:0] cnfg_p;
    logic [B_MAX_W-1:0] cnfg_b;
    logic               start_pls;
    logic               stop_pls;
    logic               busy;
    logic               fit_req_vld;
    logic               fit_req_rdy;
    logic [P_IDX_W-1:0] fit_req_p_idx;
    logic [B_IDX_W-1:0] fit_req_b_idx;
    logic               fit_req_last;
    logic               fit_rsp_vld;
    logic [FIT_W-1:0]   fit_rsp_val;
    logic               done_pls;
    logic [P_IDX_W-1:0] best_idx;
    logic [FIT_W-1:0]   best_fit;

    int n_checks = 0;
    int n_fail   = 0;

    ga_fit_sched #(.P_MAX(P_MAX), .B_MAX(B_MAX), .FIT_W(FIT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .cnfg_p       (cnfg_p),
        .cnfg_b       (cnfg_b),
        .start_pls    (start_pls),
        .stop_pls     (stop_pls),
        .busy         (busy),
        .fit_req_vld  (fit_req_vld),
        .fit_req_rdy  (fit_req_rdy),
        .fit_req_p_idx(fit_req_p_idx),
        .fit_req_b_idx(fit_req_b_idx),
        .fit_req_last (fit_req_last),
        .fit_rsp_vld  (fit_rsp_vld),
        .fit_rsp_val  (fit_rsp_val),
        .done_pls     (done_pls),
        .best_idx     (best_idx),
        .best_fit     (best_fit)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vals_t pack8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        vals_t v;
        v[0] = FIT_W'(a0); v[1] = FIT_W'(a1); v[2] = FIT_W'(a2); v[3] = FIT_W'(a3);
        v[4] = FIT_W'(a4); v[5] = FIT_W'(a5); v[6] = FIT_W'(a6); v[7] = FIT_W'(a7);
        return v;
    endfunction

    function automatic int clamp(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Reference: scan individuals in order, keep first strictly-smaller value.
    task automatic model_best(input int lp, input int lb, input vals_t vals,
                              output int idx, output int fit);
        idx = 0;
        fit = ONES;
        if (lp > 0 && lb > 0) begin
            for (int p = 0; p < lp; p++) begin
                if (int'(vals[p]) < fit) begin
                    fit = int'(vals[p]);
                    idx = p;
                end
            end
        end
    endtask

    task automatic idle_inputs();
        start_pls   = 1'b0;
        stop_pls    = 1'b0;
        fit_req_rdy = 1'b0;
        fit_rsp_vld = 1'b0;
        fit_rsp_val = '0;
    endtask

    // Runs one generation; called and returns on a falling edge.
    task automatic run_gen(input int cp, input int cb, input int mode, input vals_t vals,
                           output res_t r);
        int lp = clamp(cp, P_MAX);
        int lb = clamp(cb, B_MAX);
        int k = 0;
        int post = -1;
        bit waiting = 1'b0;
        int wait_cnt = 0;
        int wait_p = 0;
        bit prev_stall = 1'b0;
        logic [P_IDX_W-1:0] prev_p = '0;
        logic [B_IDX_W-1:0] prev_b = '0;
        logic prev_last = 1'b0;
        int exp_p, exp_b;
        r = '{default: 0};
        r.seq_ok = 1'b1; r.stable_ok = 1'b1; r.wait_ok = 1'b1; r.done_cycle = -1;
        cnfg_p    = P_MAX_W'(cp);
        cnfg_b    = B_MAX_W'(cb);
        start_pls = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 600; i++) begin
            start_pls   = 1'b0;
            fit_rsp_vld = 1'b0;
            if (i == 0) r.first_vld = fit_req_vld;
            if (done_pls) begin
                r.n_done++;
                if (post < 0) begin post = 0; r.done_cycle = i; end
            end
            if (fit_req_vld && prev_stall &&
                (fit_req_p_idx !== prev_p || fit_req_b_idx !== prev_b || fit_req_last !== prev_last))
                r.stable_ok = 1'b0;
            if (waiting && fit_req_vld) r.wait_ok = 1'b0;
            if (waiting) begin
                if (wait_cnt == 0) begin
                    fit_rsp_vld = 1'b1;
                    fit_rsp_val = vals[wait_p % 8];
                    waiting     = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end else if (mode == 2 && $urandom_range(0, 3) == 0) begin
                fit_rsp_vld = 1'b1;
                fit_rsp_val = '0;
            end
            if (mode == 2 && i == 2 && lp > 0 && lb > 0) begin
                start_pls = 1'b1;
                cnfg_p    = P_MAX_W'(1);
                cnfg_b    = B_MAX_W'(1);
            end
            case (mode)
                0:       fit_req_rdy = 1'b1;
                1:       fit_req_rdy = (i % 2 == 0);
                default: fit_req_rdy = 1'($urandom_range(0, 1));
            endcase
            if (fit_req_vld && fit_req_rdy) begin
                if (lb == 0) begin
                    r.seq_ok = 1'b0;
                end else begin
                    exp_p = k / lb;
                    exp_b = k % lb;
                    if (int'(fit_req_p_idx) != exp_p || int'(fit_req_b_idx) != exp_b ||
                        fit_req_last !== (exp_b == lb - 1))
                        r.seq_ok = 1'b0;
                    if (fit_req_last) begin
                        waiting  = 1'b1;
                        wait_cnt = (mode == 2) ? int'($urandom_range(0, 2)) : 0;
                        wait_p   = exp_p;
                    end
                end
                k++;
            end
            prev_stall = fit_req_vld && !fit_req_rdy;
            prev_p     = fit_req_p_idx;
            prev_b     = fit_req_b_idx;
            prev_last  = fit_req_last;
            if (post >= 0) begin
                if (post == 3) break;
                post++;
            end
            @(negedge clk);
        end
        idle_inputs();
        r.n_xfer = k;
    endtask

    task automatic verify_gen(input string tag, input int cp, input int cb, input int mode,
                              input vals_t vals, input int exp_idx, input int exp_fit,
                              input int exp_n);
        res_t r;
        run_gen(cp, cb, mode, vals, r);
        check({tag, " transfers"}, r.n_xfer, exp_n);
        check({tag, " done_pls count"}, r.n_done, 1);
        check({tag, " best_idx"}, best_idx, exp_idx);
        check({tag, " best_fit"}, best_fit, exp_fit);
        check({tag, " p/b/last order"}, r.seq_ok, 1);
        check({tag, " stall stability"}, r.stable_ok, 1);
        check({tag, " vld low in wait"}, r.wait_ok, 1);
        check({tag, " vld cycle after start"}, r.first_vld, (exp_n > 0));
    endtask

    vec_t tbl[6];

    initial begin
        int idx, fit, cp, cb;
        vals_t v;

        tbl[0] = '{3, 2, 0, pack8(50, 20, 30, 0, 0, 0, 0, 0), 1, 20, 6};
        tbl[1] = '{2, 3, 1, pack8(7, 9, 0, 0, 0, 0, 0, 0), 0, 7, 6};
        tbl[2] = '{4, 1, 0, pack8(10, 10, 5, 5, 0, 0, 0, 0), 2, 5, 4};
        tbl[3] = '{15, 7, 0, pack8(100, 90, 80, 70, 60, 50, 40, 45), 6, 40, 32};
        tbl[4] = '{2, 2, 0, pack8(ONES, ONES, 0, 0, 0, 0, 0, 0), 0, ONES, 4};
        tbl[5] = '{1, 4, 1, pack8(0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 4};

        rst = 1'b1;
        cnfg_p = '0;
        cnfg_b = '0;
        idle_inputs();
        repeat (2) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset fit_req_vld", fit_req_vld, 0);
        check("reset fit_req_last", fit_req_last, 0);
        check("reset done_pls", done_pls, 0);
        check("reset p_idx", fit_req_p_idx, 0);
        check("reset b_idx", fit_req_b_idx, 0);
        check("reset best_idx", best_idx, 0);
        check("reset best_fit", best_fit, ONES);
        rst = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 6; t++)
            verify_gen($sformatf("vec%0d", t), tbl[t].cp, tbl[t].cb, tbl[t].mode,
                       tbl[t].vals, tbl[t].exp_idx, tbl[t].exp_fit, tbl[t].exp_n);

        // Best outputs hold while idle, and stray responses are ignored.
        fit_rsp_vld = 1'b1;
        fit_rsp_val = '0;
        @(negedge clk);
        fit_rsp_vld = 1'b0;
        @(negedge clk);
        check("idle hold best_fit", best_fit, 0);
        check("idle hold busy", busy, 0);

        // Abort in WAIT_RSP of p=1 with a same-cycle response of 0.
        cnfg_p = 4'd3; cnfg_b = 3'd1; start_pls = 1'b1;
        @(negedge clk);
        start_pls = 1'b0;
        check("stop seq p0 vld", fit_req_vld, 1);
        check("stop seq p0 last", fit_req_last, 1);
        fit_req_rdy = 1'b1;
        @(negedge clk);
        fit_req_rdy = 1'b0;
        check("stop seq wait vld", fit_req_vld, 0);
        fit_rsp_vld = 1'b1; fit_rsp_val = 12'd50;
        @(negedge clk);
        fit_rsp_vld = 1'b0;
        check("stop seq p1 idx", fit_req_p_idx, 1);
        fit_req_rdy = 1'b1;
        @(negedge clk);
        fit_req_rdy = 1'b0;
        fit_rsp_vld = 1'b1; fit_rsp_val = 12'd0; stop_pls = 1'b1;
        @(negedge clk);
        fit_rsp_vld = 1'b0; stop_pls = 1'b0;
        check("stop busy", busy, 0);
        check("stop vld", fit_req_vld, 0);
        check("stop no done", done_pls, 0);
        check("stop best_fit", best_fit, 50);
        check("stop best_idx", best_idx, 0);
        @(negedge clk);
        check("stop no late done", done_pls, 0);

        // Zero-size generation, with a start pulse while busy.
        cnfg_p = 4'd0; cnfg_b = 3'd2; start_pls = 1'b1;
        @(negedge clk);
        cnfg_p = 4'd3; cnfg_b = 3'd1;
        check("zero busy", busy, 1);
        check("zero early done", done_pls, 0);
        @(negedge clk);
        start_pls = 1'b0;
        check("zero done", done_pls, 1);
        check("zero vld", fit_req_vld, 0);
        check("zero best_idx", best_idx, 0);
        check("zero best_fit", best_fit, ONES);
        @(negedge clk);
        check("zero ignored start busy", busy, 0);
        check("zero single done", done_pls, 0);

        // Reset while in ISSUE, then a normal generation.
        cnfg_p = 4'd2; cnfg_b = 3'd2; start_pls = 1'b1;
        @(negedge clk);
        start_pls = 1'b0;
        fit_req_rdy = 1'b1;
        @(negedge clk);
        fit_req_rdy = 1'b0;
        check("rst seq b_idx before", fit_req_b_idx, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst mid busy", busy, 0);
        check("rst mid vld", fit_req_vld, 0);
        check("rst mid last", fit_req_last, 0);
        check("rst mid done", done_pls, 0);
        check("rst mid b_idx", fit_req_b_idx, 0);
        check("rst mid p_idx", fit_req_p_idx, 0);
        check("rst mid best_fit", best_fit, ONES);
        rst = 1'b0;
        verify_gen("after rst", 2, 2, 0, pack8(9, 3, 0, 0, 0, 0, 0, 0), 1, 3, 4);

        for (int n = 0; n < 20; n++) begin
            cp = int'($urandom_range(0, 10));
            cb = int'($urandom_range(0, 5));
            for (int j = 0; j < 8; j++)
                v[j] = ($urandom_range(0, 9) == 0) ? FIT_W'(ONES) : FIT_W'($urandom_range(0, 15));
            model_best(clamp(cp, P_MAX), clamp(cb, B_MAX), v, idx, fit);
            verify_gen($sformatf("rand%0d p%0d b%0d", n, cp, cb), cp, cb, 2, v, idx, fit,
                       clamp(cp, P_MAX) * clamp(cb, B_MAX));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
